plot_buffer: RTL and testbench
==============================

# plot_buffer

Downstream stage of the screen-drawing engines (`fillscreen`, circle and line plotters). It accepts their free-running `vga_x`/`vga_y`/`vga_colour`/`vga_plot` pixel stream, which has no backpressure. Each in-range pixel is converted to a linear framebuffer address and queued. The queue drains into the framebuffer write port under a valid/ready handshake, absorbing memory stalls such as scan-out contention. Losses from off-screen or overflow conditions are flagged, never silent.

## Interface
- `DEPTH`, 16: FIFO entries, power of two, 4..256.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `vga_x` in 8: pixel column.
- `vga_y` in 7: pixel row.
- `vga_colour` in 3: pixel colour.
- `vga_plot` in 1: pixel is valid this cycle; sampled on every edge; cannot be stalled.
- `fb_addr` out 15: linear address, `vga_y*160 + vga_x`.
- `fb_data` out 3: colour for `fb_addr`.
- `fb_we` out 1: write request (valid).
- `fb_ready` in 1: framebuffer accepts; a transfer occurs on any edge where `fb_we && fb_ready`.
- `count` out $clog2(DEPTH)+1: FIFO occupancy, excluding the output register.
- `overflow` out 1: sticky; an in-range plot was dropped because the FIFO was full.
- `clipped` out 1: sticky; a plot with `vga_x>=160` or `vga_y>=120` was dropped.

## Operation
- **Reset.** `rst` high at an edge resets the block:
  - FIFO empties; output register becomes invalid.
  - `fb_we=0`, `fb_addr=0`, `fb_data=0`, `count=0`, `overflow=0`, `clipped=0`.
  - Reset mid-operation discards all queued pixels; nothing is written afterwards.
  - Sticky flags clear only on reset.
- **Accept.** On an edge with `vga_plot=1`:
  - If out of range: drop, set `clipped`.
  - Else if `count==DEPTH`: drop, set `overflow`. This applies even if a pop happens on the same edge.
  - Else push `{addr, colour}`.
- **Address.**
  - `addr = (y<<7) + (y<<5) + x`, computed at push time in 15 bits. It is combinational from the inputs, with no multiplier.
  - Maximum address is 19199.
- **Drain.**
  - The output register loads the FIFO head when it is invalid, or valid and transferring on that edge.
  - Push and pop on the same edge leave `count` unchanged.
  - The FIFO's own bypass is not used: a pixel always spends at least one cycle in the FIFO.
- **Hold.** While `fb_we=1 && fb_ready=0`, `fb_addr`/`fb_data`/`fb_we` hold stable. `fb_we` never drops without a transfer.
- **Capacity.** Total buffering is DEPTH+1 pixels (FIFO plus output register).
- **Ordering.** Pixels emerge in strict arrival order; no coalescing of duplicate addresses.

## Timing
- **Latency.** With the block empty and `fb_ready=1`, `vga_plot=1` sampled at edge k gives `fb_we=1` after edge k+1. The transfer completes at edge k+2.
- **Throughput.** Sustained throughput is 1 pixel/cycle with `fb_ready` held high, so a full `fillscreen` pass (19200 consecutive plots) never overflows.
- **Stalls.** Continuous plotting with `fb_ready=0` fills the output register and then the FIFO. The (DEPTH+2)th plot after the stall begins is the first dropped.
- **Flag timing.** `overflow` and `clipped` rise on the edge of the offending sample and are visible in the following cycle.
- **Count.** `count` is registered and reflects pushes/pops of the previous edge.

## Structure
- **Package `vga_pkg`:**
  - `SCREEN_W=160`, `SCREEN_H=120`, `FB_AW=15`, `COLOUR_W=3`.
  - `typedef struct packed {logic [14:0] addr; logic [2:0] colour;} fb_word_t`.
  - Function `xy_to_addr`.
- **Sub-module `sync_fifo`.** Parameterised on DEPTH and element type `fb_word_t`. It has:
  - push/pop inputs, full/empty flags and `count`;
  - registered head read;
  - pointers one bit wider than the index to separate full from empty.
- **Top level.** `plot_buffer` holds the range check, address computation, output register and sticky flags.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with `vga_plot=1` -> all outputs 0; no push occurs.
- **Single pixel.** (x=5, y=3, colour=6), `fb_ready=1` -> `fb_we` high for exactly one cycle, 2 edges after the sample, with `fb_addr=485` and `fb_data=6`.
- **Full screen.** Sweep x=0..159 (outer), y=0..119 (inner), colour=x[2:0], `fb_ready=1` -> 19200 writes in order with the correct addresses. First is 0, last is 19199 colour 7; `overflow=0` and `clipped=0` at the end.
- **Stall and overflow.** `DEPTH=16`; `fb_ready=0` for 30 cycles under continuous plots -> `count` saturates at 16 and `overflow` rises on the 18th plot. `fb_addr` is stable throughout the stall. On releasing `fb_ready`, exactly 17 writes emerge, in order.
- **Clipping.** Plots at (160, 0) and (0, 120) -> no write; `clipped=1`. A following in-range plot is still written.
- **Reset mid-drain.** `rst` with `count=10` and `fb_ready=0` -> after the edge, `count=0` and `fb_we=0`. No stale writes appear after `fb_ready` goes high.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the pixel-plot path into the framebuffer.
//   SCREEN_W/SCREEN_H : visible screen size (160 x 120)
//   FB_AW/COLOUR_W    : framebuffer address and colour widths
//   fb_word_t         : one queued framebuffer write {addr, colour}
//   xy_to_addr        : linear address y*160 + x, built from shifts only
package vga_pkg;

  localparam logic [7:0] SCREEN_W = 8'd160;
  localparam logic [6:0] SCREEN_H = 7'd120;
  localparam int FB_AW    = 15;
  localparam int COLOUR_W = 3;

  typedef struct packed {
    logic [FB_AW-1:0]    addr;
    logic [COLOUR_W-1:0] colour;
  } fb_word_t;

  // 160 = 128 + 32, so y*160 is two shifted copies of y.
  function automatic logic [FB_AW-1:0] xy_to_addr(input logic [7:0] x, input logic [6:0] y);
    logic [FB_AW-1:0] yw;
    logic [FB_AW-1:0] xw;
    yw = {8'd0, y};
    xw = {7'd0, x};
    return (yw << 7) + (yw << 5) + xw;
  endfunction

endpackage

// File: rtl/plot_buffer_if.sv
// Framebuffer write port with valid/ready handshake.
//   fb_addr  : linear pixel address
//   fb_data  : pixel colour
//   fb_we    : write request (valid)
//   fb_ready : framebuffer accepts this cycle
// master = plot_buffer side, slave = framebuffer side.
interface plot_buffer_if;
  import vga_pkg::*;

  logic [FB_AW-1:0]    fb_addr;
  logic [COLOUR_W-1:0] fb_data;
  logic                fb_we;
  logic                fb_ready;

  modport master (output fb_addr, output fb_data, output fb_we, input fb_ready);
  modport slave  (input fb_addr, input fb_data, input fb_we, output fb_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, no same-cycle bypass: written data is visible at the
// head from the cycle after the push.
//   clk, rst        : clock, synchronous active-high reset
//   push, wr_data   : enqueue (ignored when full)
//   pop             : dequeue head (ignored when empty)
//   rd_data         : current head, read from storage registers
//   full, empty     : status flags
//   count           : occupancy, 0..DEPTH
module sync_fifo
  import vga_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = fb_word_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       wr_data,
  input  logic                   pop,
  output T                       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = 1;
  localparam logic [AW:0] FULL_CNT = DEPTH;

  T           mem [DEPTH];
  // One extra pointer bit tells full (MSBs differ) from empty (equal).
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == FULL_CNT);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/plot_buffer.sv
// Buffers the free-running plotter pixel stream into the framebuffer write
// port, absorbing memory stalls. Off-screen and overflow drops are flagged.
//   clk, rst                          : clock, synchronous active-high reset
//   vga_x/vga_y/vga_colour/vga_plot   : pixel stream, no backpressure
//   fb                                : framebuffer write port (master)
//   count                             : FIFO occupancy (output reg excluded)
//   overflow                          : sticky, in-range pixel lost to full FIFO
//   clipped                           : sticky, off-screen pixel dropped
module plot_buffer
  import vga_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             vga_x,
  input  logic [6:0]             vga_y,
  input  logic [COLOUR_W-1:0]    vga_colour,
  input  logic                   vga_plot,
  plot_buffer_if.master          fb,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   clipped
);

  logic     in_range;
  logic     fifo_full;
  logic     fifo_empty;
  logic     push;
  logic     pop;
  logic     xfer;
  fb_word_t in_word;
  fb_word_t head;
  fb_word_t out_word;
  logic     out_valid;

  assign in_range       = (vga_x < SCREEN_W) && (vga_y < SCREEN_H);
  assign in_word.addr   = xy_to_addr(vga_x, vga_y);
  assign in_word.colour = vga_colour;

  // Full is judged on the registered count, so a same-edge pop does not
  // make room for an incoming pixel.
  assign push = vga_plot && in_range && !fifo_full;
  assign xfer = out_valid && fb.fb_ready;
  assign pop  = !fifo_empty && (!out_valid || fb.fb_ready);

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (fb_word_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (in_word),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_word  <= head;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      clipped  <= 1'b0;
    end else begin
      if (vga_plot && !in_range)             clipped  <= 1'b1;
      if (vga_plot && in_range && fifo_full) overflow <= 1'b1;
    end
  end

  assign fb.fb_we   = out_valid;
  assign fb.fb_addr = out_word.addr;
  assign fb.fb_data = out_word.colour;

endmodule

// File: tb/tb_plot_buffer.sv
module tb_plot_buffer;

  logic       clk;
  logic       rst;
  logic [7:0] vx;
  logic [6:0] vy;
  logic [2:0] vc;
  logic       vplot;
  logic [4:0] cnt;
  logic       ovf;
  logic       clp;

  plot_buffer_if fbi ();

  plot_buffer #(.DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_x      (vx),
    .vga_y      (vy),
    .vga_colour (vc),
    .vga_plot   (vplot),
    .fb         (fbi),
    .count      (cnt),
    .overflow   (ovf),
    .clipped    (clp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors;
  int          miscompares;
  int          writes;
  logic [17:0] exp_q[$];
  logic [14:0] last_addr;
  logic [2:0]  last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every handshake completing on the next rising edge is matched
  // against the head of the scoreboard.
  always @(negedge clk) begin
    if (fbi.fb_we === 1'b1 && fbi.fb_ready === 1'b1) begin
      writes++;
      last_addr = fbi.fb_addr;
      last_data = fbi.fb_data;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", fbi.fb_addr, fbi.fb_data);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({fbi.fb_addr, fbi.fb_data} !== e) begin
          miscompares++;
          $display("FAIL write_order: got addr %0d data %0d, expected addr %0d data %0d",
                   fbi.fb_addr, fbi.fb_data, e[17:3], e[2:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_plot(input int x, input int y, input int c);
    vx    = 8'(x);
    vy    = 7'(y);
    vc    = 3'(c);
    vplot = 1'b1;
  endtask

  task automatic expect_px(input int x, input int y, input int c);
    logic [14:0] a;
    a = 15'(y * 160 + x);
    exp_q.push_back({a, 3'(c)});
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    vectors     = 0;
    miscompares = 0;
    writes      = 0;
    rst = 1'b1;
    fbi.fb_ready = 1'b1;
    set_plot(5, 3, 6);

    // Reset held with a plot presented
    tick();
    tick();
    chk("rst_we",    fbi.fb_we,   0);
    chk("rst_addr",  fbi.fb_addr, 0);
    chk("rst_data",  fbi.fb_data, 0);
    chk("rst_count", cnt, 0);
    chk("rst_ovf",   ovf, 0);
    chk("rst_clp",   clp, 0);
    rst   = 1'b0;
    vplot = 1'b0;
    tick();
    chk("rst_nopush_count", cnt, 0);
    chk("rst_nopush_we",    fbi.fb_we, 0);

    // Single pixel latency: sampled at edge k, fb_we after k+1, done at k+2
    set_plot(5, 3, 6);
    expect_px(5, 3, 6);
    tick();
    vplot = 1'b0;
    chk("single_we_k",    fbi.fb_we, 0);
    chk("single_count_k", cnt, 1);
    tick();
    chk("single_we_k1",   fbi.fb_we, 1);
    chk("single_addr",    fbi.fb_addr, 485);
    chk("single_data",    fbi.fb_data, 6);
    tick();
    chk("single_we_k2",   fbi.fb_we, 0);
    drain(5);

    // Full screen sweep, x outer, y inner
    for (int x = 0; x < 160; x++) begin
      for (int y = 0; y < 120; y++) begin
        set_plot(x, y, x % 8);
        expect_px(x, y, x % 8);
        tick();
      end
    end
    vplot = 1'b0;
    drain(50);
    chk("full_last_addr", last_addr, 19199);
    chk("full_last_data", last_data, 7);
    chk("full_ovf",       ovf, 0);
    chk("full_clp",       clp, 0);

    // Clipping
    set_plot(160, 0, 1);
    tick();
    chk("clip_x_flag", clp, 1);
    set_plot(0, 120, 2);
    tick();
    vplot = 1'b0;
    tick();
    chk("clip_count", cnt, 0);
    chk("clip_we",    fbi.fb_we, 0);
    chk("clip_ovf",   ovf, 0);
    set_plot(7, 1, 3);
    expect_px(7, 1, 3);
    tick();
    vplot = 1'b0;
    drain(10);
    chk("clip_after_addr", last_addr, 167);
    chk("clip_sticky",     clp, 1);

    // Stall and overflow: 30 plots with fb_ready low
    fbi.fb_ready = 1'b0;
    w0 = writes;
    for (int i = 0; i < 30; i++) begin
      set_plot(20 + i, 10, i % 8);
      if (i < 17) expect_px(20 + i, 10, i % 8);
      tick();
      chk("stall_count", cnt, (i == 0) ? 1 : ((i < 16) ? i : 16));
      chk("stall_ovf",   ovf, (i >= 17) ? 1 : 0);
      if (i >= 1) begin
        chk("stall_we",   fbi.fb_we, 1);
        chk("stall_addr", fbi.fb_addr, 1620);
      end
    end
    vplot = 1'b0;
    fbi.fb_ready = 1'b1;
    drain(40);
    repeat (5) tick();
    chk("stall_writes", writes - w0, 17);
    chk("stall_empty",  cnt, 0);

    // Reset mid-drain
    fbi.fb_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      set_plot(i, 50, 5);
      tick();
    end
    vplot = 1'b0;
    chk("mid_count_pre", cnt, 10);
    chk("mid_we_pre",    fbi.fb_we, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_count", cnt, 0);
    chk("mid_we",    fbi.fb_we, 0);
    chk("mid_ovf",   ovf, 0);
    chk("mid_clp",   clp, 0);
    w0 = writes;
    fbi.fb_ready = 1'b1;
    repeat (20) tick();
    chk("mid_no_stale", writes - w0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
